// File: rtl/shot_capture.sv
// Shot capture: synchronizes and debounces board switches, then
// commits single-switch clears as shots and flags illegal moves.
module shot_capture #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] sw,
  input  logic        turn_en,
  input  logic        ok,
  output logic [15:0] old_state,
  output logic [15:0] new_state,
  output logic        ready,
  output logic        shot_valid,
  output logic [3:0]  shot_idx,
  output logic        bad_move
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES);

  typedef enum logic [2:0] {
    LOAD,
    IDLE,
    CHECK,
    FIRE,
    REJECT,
    WAIT_RESTORE
  } state_t;

  state_t      state, state_d;
  logic [15:0] s1, s2, deb;
  logic [CW-1:0] cnt;
  logic        deb_stable;
  logic [15:0] old_d, new_d;
  logic [3:0]  idx_d;
  logic        sv_d, bm_d;

  function automatic logic [3:0] low_idx(input logic [15:0] v);
    low_idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) low_idx = 4'(i);
    end
  endfunction

  // count restarts on the edge where s2 takes a new value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1  <= '0;
      s2  <= '0;
      deb <= '0;
      cnt <= '0;
    end else begin
      s1 <= sw;
      s2 <= s1;
      if (s1 != s2) cnt <= '0;
      else if (cnt != CMAX) cnt <= cnt + 1'b1;
      if (cnt == CMAX) deb <= s2;
    end
  end

  assign deb_stable = (cnt == CMAX) && (deb == s2);
  assign ready      = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LOAD;
      old_state  <= '0;
      new_state  <= '0;
      shot_idx   <= '0;
      shot_valid <= 1'b0;
      bad_move   <= 1'b0;
    end else begin
      state      <= state_d;
      old_state  <= old_d;
      new_state  <= new_d;
      shot_idx   <= idx_d;
      shot_valid <= sv_d;
      bad_move   <= bm_d;
    end
  end

  always_comb begin
    state_d = state;
    old_d   = old_state;
    new_d   = new_state;
    idx_d   = shot_idx;
    sv_d    = 1'b0;
    bm_d    = 1'b0;
    unique case (state)
      LOAD: begin
        if (deb_stable) begin
          old_d   = deb;
          new_d   = deb;
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (turn_en && deb_stable && deb != old_state) begin
          new_d   = deb;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (ok) begin
          sv_d    = 1'b1;
          idx_d   = low_idx(old_state & ~new_state);
          state_d = FIRE;
        end else begin
          bm_d    = 1'b1;
          state_d = REJECT;
        end
      end
      FIRE: begin
        old_d   = new_state;
        state_d = IDLE;
      end
      REJECT: begin
        new_d   = old_state;
        state_d = WAIT_RESTORE;
      end
      WAIT_RESTORE: begin
        if (deb_stable && deb == old_state) begin
          new_d   = old_state;
          state_d = IDLE;
        end
      end
      default: state_d = LOAD;
    endcase
  end

endmodule

// File: tb/tb_shot_capture.sv
// Directed bench for shot_capture with a reference move checker
// driving ok.
module tb_shot_capture;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] sw = '0;
  logic        turn_en = 1'b0;
  logic        ok;
  logic [15:0] old_state, new_state;
  logic        ready, shot_valid, bad_move;
  logic [3:0]  shot_idx;

  int checks = 0;
  int failures = 0;
  int both_cnt = 0;

  shot_capture #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sw(sw),
    .turn_en(turn_en),
    .ok(ok),
    .old_state(old_state),
    .new_state(new_state),
    .ready(ready),
    .shot_valid(shot_valid),
    .shot_idx(shot_idx),
    .bad_move(bad_move)
  );

  always #5 clk = ~clk;

  assign ok = ((new_state & ~old_state) == 16'h0)
           && $onehot(old_state & ~new_state);

  always @(negedge clk) begin
    if (shot_valid && bad_move) both_cnt++;
  end

  task automatic wait_pulse(input int lim, output int n,
                            output logic r1, output logic r2);
    n = 0;
    r1 = 1'b0;
    r2 = 1'b0;
    do begin
      r2 = r1;
      r1 = ready;
      @(negedge clk);
      n++;
    end while (!(shot_valid || bad_move) && n < lim);
  endtask

  task automatic test_reset;
    int n;
    int pulses;
    rst_n = 1'b0;
    turn_en = 1'b0;
    sw = 16'h0007;
    repeat (3) @(negedge clk);
    checks++;
    if ({ready, shot_valid, bad_move} !== 3'b000) begin
      failures++;
      $display("FAIL reset_ctl got=%b exp=000",
               {ready, shot_valid, bad_move});
    end
    checks++;
    if (old_state !== 16'h0 || new_state !== 16'h0 || shot_idx !== 4'h0) begin
      failures++;
      $display("FAIL reset_data old=%h new=%h idx=%h exp=0",
               old_state, new_state, shot_idx);
    end
    rst_n = 1'b1;
    n = 0;
    pulses = 0;
    while (!ready && n < 12) begin
      @(negedge clk);
      n++;
      pulses += int'(shot_valid) + int'(bad_move);
    end
    checks++;
    if (!ready || n > 8) begin
      failures++;
      $display("FAIL load_latency cycles=%0d ready=%b exp<=8", n, ready);
    end
    checks++;
    if (old_state !== 16'h0007 || new_state !== 16'h0007) begin
      failures++;
      $display("FAIL load_value old=%h new=%h exp=0007",
               old_state, new_state);
    end
    checks++;
    if (pulses != 0) begin
      failures++;
      $display("FAIL load_pulses got=%0d exp=0", pulses);
    end
  endtask

  task automatic test_shot(input logic [15:0] s, input logic [3:0] eidx);
    int n;
    logic r1, r2;
    turn_en = 1'b1;
    sw = s;
    wait_pulse(25, n, r1, r2);
    checks++;
    if (shot_valid !== 1'b1 || bad_move !== 1'b0) begin
      failures++;
      $display("FAIL shot_pulse sv=%b bm=%b exp sv=1 bm=0",
               shot_valid, bad_move);
    end
    checks++;
    if (shot_idx !== eidx) begin
      failures++;
      $display("FAIL shot_idx got=%0d exp=%0d", shot_idx, eidx);
    end
    checks++;
    if ({r2, r1} !== 2'b10) begin
      failures++;
      $display("FAIL shot_latency ready_hist=%b exp=10", {r2, r1});
    end
    @(negedge clk);
    checks++;
    if (shot_valid !== 1'b0 || ready !== 1'b1) begin
      failures++;
      $display("FAIL shot_after sv=%b ready=%b exp sv=0 ready=1",
               shot_valid, ready);
    end
    checks++;
    if (old_state !== s || new_state !== s) begin
      failures++;
      $display("FAIL shot_commit old=%h new=%h exp=%h",
               old_state, new_state, s);
    end
  endtask

  task automatic test_reject;
    int n;
    int pulses;
    int rdy;
    logic r1, r2;
    turn_en = 1'b1;
    sw = 16'h0007;
    wait_pulse(25, n, r1, r2);
    checks++;
    if (bad_move !== 1'b1 || shot_valid !== 1'b0) begin
      failures++;
      $display("FAIL reject_pulse bm=%b sv=%b exp bm=1 sv=0",
               bad_move, shot_valid);
    end
    @(negedge clk);
    checks++;
    if (bad_move !== 1'b0 || ready !== 1'b0 || old_state !== 16'h0004) begin
      failures++;
      $display("FAIL reject_after bm=%b ready=%b old=%h exp 0 0 0004",
               bad_move, ready, old_state);
    end
    checks++;
    if (shot_idx !== 4'd1) begin
      failures++;
      $display("FAIL idx_hold got=%0d exp=1", shot_idx);
    end
    pulses = 0;
    rdy = 0;
    repeat (10) begin
      @(negedge clk);
      pulses += int'(shot_valid) + int'(bad_move);
      rdy += int'(ready);
    end
    checks++;
    if (pulses != 0 || rdy != 0) begin
      failures++;
      $display("FAIL reject_wait pulses=%0d ready_cycles=%0d exp 0 0",
               pulses, rdy);
    end
    sw = 16'h0004;
    n = 0;
    while (!ready && n < 25) begin
      @(negedge clk);
      n++;
      pulses += int'(shot_valid) + int'(bad_move);
    end
    checks++;
    if (!ready || pulses != 0) begin
      failures++;
      $display("FAIL restore ready=%b pulses=%0d exp ready=1 pulses=0",
               ready, pulses);
    end
    checks++;
    if (old_state !== 16'h0004 || new_state !== 16'h0004) begin
      failures++;
      $display("FAIL restore_state old=%h new=%h exp=0004",
               old_state, new_state);
    end
  endtask

  task automatic test_glitch;
    int pulses;
    int low;
    pulses = 0;
    low = 0;
    sw = 16'h0005;
    repeat (2) @(negedge clk);
    sw = 16'h0004;
    repeat (15) begin
      @(negedge clk);
      pulses += int'(shot_valid) + int'(bad_move);
      low += int'(!ready);
    end
    checks++;
    if (pulses != 0 || low != 0 || old_state !== 16'h0004) begin
      failures++;
      $display("FAIL glitch pulses=%0d not_ready=%0d old=%h exp 0 0 0004",
               pulses, low, old_state);
    end
  endtask

  task automatic test_turn_gate;
    int n;
    int pulses;
    logic r1, r2;
    pulses = 0;
    turn_en = 1'b0;
    sw = 16'h0000;
    repeat (15) begin
      @(negedge clk);
      pulses += int'(shot_valid) + int'(bad_move);
    end
    checks++;
    if (pulses != 0 || old_state !== 16'h0004) begin
      failures++;
      $display("FAIL turn_gate pulses=%0d old=%h exp 0 0004",
               pulses, old_state);
    end
    turn_en = 1'b1;
    wait_pulse(10, n, r1, r2);
    checks++;
    if (shot_valid !== 1'b1 || shot_idx !== 4'd2 || n != 2) begin
      failures++;
      $display("FAIL turn_shot sv=%b idx=%0d cycles=%0d exp 1 2 2",
               shot_valid, shot_idx, n);
    end
    @(negedge clk);
    checks++;
    if (old_state !== 16'h0000) begin
      failures++;
      $display("FAIL turn_commit old=%h exp=0000", old_state);
    end
  endtask

  task automatic test_reset_in_check;
    int n;
    int pulses;
    pulses = 0;
    turn_en = 1'b1;
    sw = 16'h0001;
    n = 0;
    while (ready && n < 25) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (ready !== 1'b0 || new_state !== 16'h0001) begin
      failures++;
      $display("FAIL reach_check ready=%b new=%h exp 0 0001",
               ready, new_state);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ready, shot_valid, bad_move} !== 3'b000 || old_state !== 16'h0
        || new_state !== 16'h0 || shot_idx !== 4'h0) begin
      failures++;
      $display("FAIL rst_mid ctl=%b old=%h new=%h idx=%h exp all 0",
               {ready, shot_valid, bad_move}, old_state, new_state, shot_idx);
    end
    repeat (2) begin
      @(negedge clk);
      pulses += int'(shot_valid) + int'(bad_move);
    end
    rst_n = 1'b1;
    checks++;
    if (ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_load ready=%b exp=0", ready);
    end
    n = 0;
    while (!ready && n < 12) begin
      @(negedge clk);
      n++;
      pulses += int'(shot_valid) + int'(bad_move);
    end
    checks++;
    if (!ready || old_state !== 16'h0001 || pulses != 0) begin
      failures++;
      $display("FAIL rst_reload ready=%b old=%h pulses=%0d exp 1 0001 0",
               ready, old_state, pulses);
    end
  endtask

  task automatic test_exclusive;
    checks++;
    if (both_cnt != 0) begin
      failures++;
      $display("FAIL exclusive both_high_cycles=%0d exp=0", both_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_shot(16'h0006, 4'd0);
    test_shot(16'h0004, 4'd1);
    test_reject();
    test_glitch();
    test_turn_gate();
    test_reset_in_check();
    test_exclusive();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
